// File: rtl/bias_act_pkg.sv
// Shared types and arithmetic helpers for the bias + activation pipeline.
//   act_mode_e : activation selector (none / ReLU / leaky ReLU / clamp)
//   sat_add()  : signed add with saturation to a w-bit signed range
//   activate() : applies the selected activation to a saturated value
// The helpers work on CALC_W-bit sign-extended operands so one function
// serves any lane width up to CALC_W-1 bits.
package bias_act_pkg;

  localparam int unsigned CALC_W = 32;

  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2,
    ACT_CLAMP = 2'd3
  } act_mode_e;

  typedef struct packed {
    logic                     ovf;
    logic signed [CALC_W-1:0] val;
  } sat_res_t;

  // Sum is formed one bit wider than the operands so it can never wrap
  // before being compared against the w-bit limits.
  function automatic sat_res_t sat_add(input logic signed [CALC_W-1:0] a,
                                       input logic signed [CALC_W-1:0] b,
                                       input int unsigned              w);
    logic signed [CALC_W:0] sum;
    logic signed [CALC_W:0] hi;
    logic signed [CALC_W:0] lo;
    sat_res_t               r;
    sum   = (CALC_W+1)'(a) + (CALC_W+1)'(b);
    hi    = $signed(((CALC_W+1)'(1) << (w - 1)) - (CALC_W+1)'(1));
    lo    = -hi - 1;
    r.ovf = 1'b0;
    r.val = sum[CALC_W-1:0];
    if (sum > hi) begin
      r.val = hi[CALC_W-1:0];
      r.ovf = 1'b1;
    end else if (sum < lo) begin
      r.val = lo[CALC_W-1:0];
      r.ovf = 1'b1;
    end
    return r;
  endfunction

  // A negative clamp ceiling behaves as 0, so clamp mode then outputs 0.
  function automatic logic signed [CALC_W-1:0] activate(input act_mode_e                mode,
                                                        input logic signed [CALC_W-1:0] s,
                                                        input logic signed [CALC_W-1:0] cmax,
                                                        input int unsigned              shift);
    logic signed [CALC_W-1:0] c;
    logic signed [CALC_W-1:0] r;
    c = (cmax < 0) ? '0 : cmax;
    r = s;
    case (mode)
      ACT_NONE:  r = s;
      ACT_RELU:  r = (s < 0) ? '0 : s;
      ACT_LEAKY: r = (s < 0) ? (s >>> shift) : s;
      ACT_CLAMP: r = (s < 0) ? '0 : ((s > c) ? c : s);
      default:   r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bias_act_lane.sv
// One lane of the bias + activation pipeline.
//   clk_i, n_rst_i : clock, asynchronous active-low reset
//   ld1_i          : load stage 1 (beat accepted)
//   ld2_i          : load stage 2 (stage 1 beat moves to output)
//   in_i, bias_i   : signed lane input and bias for the accepted beat
//   mode_i,clamp_i : activation mode / clamp ceiling captured with the beat in stage 1
//   out_o          : stage 2 register (activated output)
//   sat_o          : combinational saturation flag of the current in_i + bias_i
module bias_act_lane
  import bias_act_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned LEAKY_SHIFT = 3
) (
  input  logic              clk_i,
  input  logic              n_rst_i,
  input  logic              ld1_i,
  input  logic              ld2_i,
  input  logic [DATA_W-1:0] in_i,
  input  logic [DATA_W-1:0] bias_i,
  input  logic [1:0]        mode_i,
  input  logic [DATA_W-1:0] clamp_i,
  output logic [DATA_W-1:0] out_o,
  output logic              sat_o
);

  sat_res_t                 add_r;
  logic signed [CALC_W-1:0] act_val;
  logic [DATA_W-1:0]        s_q, s_d;
  logic [DATA_W-1:0]        out_q, out_d;

  always_comb begin
    add_r   = sat_add(CALC_W'($signed(in_i)), CALC_W'($signed(bias_i)), DATA_W);
    s_d     = add_r.val[DATA_W-1:0];
    sat_o   = add_r.ovf;
    act_val = activate(act_mode_e'(mode_i), CALC_W'($signed(s_q)),
                       CALC_W'($signed(clamp_i)), LEAKY_SHIFT);
    out_d   = act_val[DATA_W-1:0];
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      s_q   <= '0;
      out_q <= '0;
    end else begin
      if (ld1_i) s_q   <= s_d;
      if (ld2_i) out_q <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/bias_act_pipeline.sv
// Systolic-array post-processing: per-row bias add with saturation, then a
// selectable activation, in a two-stage elastic pipeline with valid/ready.
//   clk, n_rst                       : clock, asynchronous active-low reset
//   frame_start                      : next accepted beat uses bias row 0
//   bias_wr_en/addr/data             : bias bank write port (visible next cycle)
//   act_mode, clamp_max              : activation select and clamp ceiling
//   in_valid/in_ready/in_data        : input beat handshake
//   out_valid/out_ready/out_data     : output beat handshake
//   ovf_lanes, overflow, ovf_clear   : sticky per-lane saturation flags
module bias_act_pipeline
  import bias_act_pkg::*;
#(
  parameter int unsigned LANES       = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned BIAS_DEPTH  = 8,
  parameter int unsigned LEAKY_SHIFT = 3
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          frame_start,
  input  logic                          bias_wr_en,
  input  logic [$clog2(BIAS_DEPTH)-1:0] bias_wr_addr,
  input  logic [LANES*DATA_W-1:0]       bias_wr_data,
  input  logic [1:0]                    act_mode,
  input  logic [DATA_W-1:0]             clamp_max,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_W-1:0]       in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_W-1:0]       out_data,
  output logic [LANES-1:0]              ovf_lanes,
  output logic                          overflow,
  input  logic                          ovf_clear
);

  localparam int unsigned AW = $clog2(BIAS_DEPTH);

  logic                    v1_q, v1_d;
  logic                    v2_q, v2_d;
  logic                    adv1, adv2, accept, ld2;
  logic [AW-1:0]           row_q, row_d, row_use;
  logic [1:0]              mode1_q;
  logic [DATA_W-1:0]       clamp1_q;
  logic [LANES-1:0]        ovf_q, ovf_d;
  logic [LANES-1:0]        sat_vec;
  logic [LANES*DATA_W-1:0] bias_row;
  logic [LANES*DATA_W-1:0] bank_q [BIAS_DEPTH];

  // Handshake: each stage may advance when empty or when the stage behind it drains.
  always_comb begin
    adv2   = !v2_q || out_ready;
    adv1   = !v1_q || adv2;
    accept = in_valid && adv1;
    ld2    = adv2 && v1_q;
    v1_d   = adv1 ? in_valid : v1_q;
    v2_d   = adv2 ? v1_q : v2_q;
  end

  // frame_start redirects the current beat to row 0; reading the bank
  // register directly means a same-cycle write is seen only by later beats.
  always_comb begin
    row_use  = frame_start ? '0 : row_q;
    bias_row = bank_q[row_use];
    row_d    = row_q;
    if (accept) begin
      row_d = (row_use == AW'(BIAS_DEPTH - 1)) ? '0 : row_use + 1'b1;
    end else if (frame_start) begin
      row_d = '0;
    end
  end

  // Clear first, then OR in new saturations so a same-cycle set wins.
  always_comb begin
    ovf_d = ovf_q & ~{LANES{ovf_clear}};
    if (accept) ovf_d = ovf_d | sat_vec;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      row_q    <= '0;
      mode1_q  <= '0;
      clamp1_q <= '0;
      ovf_q    <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      row_q <= row_d;
      ovf_q <= ovf_d;
      if (accept) begin
        mode1_q  <= act_mode;
        clamp1_q <= clamp_max;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int unsigned i = 0; i < BIAS_DEPTH; i++) bank_q[i] <= '0;
    end else if (bias_wr_en) begin
      bank_q[bias_wr_addr] <= bias_wr_data;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    bias_act_lane #(
      .DATA_W      (DATA_W),
      .LEAKY_SHIFT (LEAKY_SHIFT)
    ) u_lane (
      .clk_i   (clk),
      .n_rst_i (n_rst),
      .ld1_i   (accept),
      .ld2_i   (ld2),
      .in_i    (in_data[g*DATA_W +: DATA_W]),
      .bias_i  (bias_row[g*DATA_W +: DATA_W]),
      .mode_i  (mode1_q),
      .clamp_i (clamp1_q),
      .out_o   (out_data[g*DATA_W +: DATA_W]),
      .sat_o   (sat_vec[g])
    );
  end

  assign in_ready  = adv1;
  assign out_valid = v2_q;
  assign ovf_lanes = ovf_q;
  assign overflow  = |ovf_q;

endmodule

// File: tb/tb_bias_act_pipeline.sv
module tb_bias_act_pipeline;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        frame_start;
  logic        bias_wr_en;
  logic [2:0]  bias_wr_addr;
  logic [63:0] bias_wr_data;
  logic [1:0]  act_mode;
  logic [7:0]  clamp_max;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [7:0]  ovf_lanes;
  logic        overflow;
  logic        ovf_clear;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bias_act_pipeline #(
    .LANES       (8),
    .DATA_W      (8),
    .BIAS_DEPTH  (8),
    .LEAKY_SHIFT (3)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .frame_start  (frame_start),
    .bias_wr_en   (bias_wr_en),
    .bias_wr_addr (bias_wr_addr),
    .bias_wr_data (bias_wr_data),
    .act_mode     (act_mode),
    .clamp_max    (clamp_max),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .ovf_lanes    (ovf_lanes),
    .overflow     (overflow),
    .ovf_clear    (ovf_clear)
  );

  typedef struct {
    logic [7:0] vin;
    logic [7:0] bias;
    logic [1:0] mode;
    logic [7:0] cmax;
    logic [7:0] exp;
    logic       ovf;
  } vec_t;

  vec_t vt[16];

  // per-beat stream tables for run_beats
  logic [7:0] s_in   [16];
  logic       s_fs   [16];
  logic       s_we   [16];
  logic [2:0] s_wa   [16];
  logic [7:0] s_wd   [16];
  logic [1:0] s_mode [16];
  logic [7:0] s_exp  [16];

  function automatic logic [63:0] rep(input logic [7:0] v);
    return {8{v}};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input logic [2:0] a, input logic [63:0] d);
    bias_wr_en   = 1'b1;
    bias_wr_addr = a;
    bias_wr_data = d;
    tick();
    bias_wr_en   = 1'b0;
  endtask

  task automatic clr_beats();
    for (int i = 0; i < 16; i++) begin
      s_in[i] = '0; s_fs[i] = 1'b0; s_we[i] = 1'b0; s_wa[i] = '0;
      s_wd[i] = '0; s_mode[i] = '0; s_exp[i] = '0;
    end
  endtask

  task automatic apply_vec(input int idx);
    int k;
    write_row(3'd0, rep(vt[idx].bias));
    ovf_clear = 1'b1;
    tick();
    ovf_clear   = 1'b0;
    act_mode    = vt[idx].mode;
    clamp_max   = vt[idx].cmax;
    in_data     = rep(vt[idx].vin);
    in_valid    = 1'b1;
    frame_start = 1'b1;
    tick();
    in_valid    = 1'b0;
    frame_start = 1'b0;
    k = 0;
    while (!out_valid && k < 8) begin
      tick();
      k++;
    end
    chk($sformatf("vec%0d_valid", idx), {63'd0, out_valid}, 64'd1);
    chk($sformatf("vec%0d_data", idx), out_data, rep(vt[idx].exp));
    chk($sformatf("vec%0d_ovf", idx), {56'd0, ovf_lanes}, {56'd0, {8{vt[idx].ovf}}});
  endtask

  // Continuous stream with out_ready high: beat i appears two edges after it is driven.
  task automatic run_beats(input int n, input string name);
    out_ready = 1'b1;
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) begin
        in_valid     = 1'b1;
        in_data      = rep(s_in[i]);
        frame_start  = s_fs[i];
        bias_wr_en   = s_we[i];
        bias_wr_addr = s_wa[i];
        bias_wr_data = rep(s_wd[i]);
        act_mode     = s_mode[i];
      end else begin
        in_valid    = 1'b0;
        frame_start = 1'b0;
        bias_wr_en  = 1'b0;
      end
      if (i >= 2) begin
        chk($sformatf("%s_v%0d", name, i - 2), {63'd0, out_valid}, 64'd1);
        chk($sformatf("%s_d%0d", name, i - 2), out_data, rep(s_exp[i - 2]));
      end else begin
        chk($sformatf("%s_lat%0d", name, i), {63'd0, out_valid}, 64'd0);
      end
      tick();
    end
    bias_wr_en = 1'b0;
    chk($sformatf("%s_drained", name), {63'd0, out_valid}, 64'd0);
  endtask

  task automatic backpressure();
    logic [7:0]  q[$];
    logic [7:0]  e;
    logic [63:0] held;
    logic        acc, fire, stall_prev;
    int          nb, got;
    nb = 0; got = 0; stall_prev = 1'b0; held = '0;
    act_mode = 2'd0;
    for (int cyc = 0; cyc < 60 && got < 12; cyc++) begin
      out_ready   = !(cyc >= 4 && cyc < 9);
      in_valid    = (nb < 12);
      in_data     = rep(8'(20 + nb));
      frame_start = (nb == 0);
      #1;
      if (stall_prev) begin
        chk($sformatf("bp_hold_c%0d", cyc), out_data, held);
        chk($sformatf("bp_holdv_c%0d", cyc), {63'd0, out_valid}, 64'd1);
      end
      if (cyc == 4 || cyc == 8) chk($sformatf("bp_inready_c%0d", cyc), {63'd0, in_ready}, 64'd0);
      acc        = in_valid && in_ready;
      fire       = out_valid && out_ready;
      stall_prev = out_valid && !out_ready;
      held       = out_data;
      @(posedge clk);
      #1;
      if (acc) begin
        q.push_back(8'(30 + nb));
        nb++;
      end
      if (fire) begin
        if (q.size() == 0) begin
          chk("bp_spurious", held, 64'd0 - 64'd1);
        end else begin
          e = q.pop_front();
          chk($sformatf("bp_beat%0d", got), held, rep(e));
        end
        got++;
      end
    end
    in_valid    = 1'b0;
    frame_start = 1'b0;
    out_ready   = 1'b1;
    chk("bp_count", 64'(got), 64'd12);
    chk("bp_left", 64'(q.size()), 64'd0);
    tick();
    chk("bp_drained", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    n_rst = 1'b0; frame_start = 1'b0; bias_wr_en = 1'b0; bias_wr_addr = '0;
    bias_wr_data = '0; act_mode = '0; clamp_max = '0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b1; ovf_clear = 1'b0;

    //          vin     bias    mode  cmax   exp     ovf
    vt[0]  = '{8'd5,   8'd10,  2'd0, 8'd0,  8'd15,  1'b0};
    vt[1]  = '{8'd120, 8'd10,  2'd0, 8'd0,  8'h7F,  1'b1};
    vt[2]  = '{8'h88,  8'hF6,  2'd0, 8'd0,  8'h80,  1'b1};
    vt[3]  = '{8'hF0,  8'd0,   2'd1, 8'd0,  8'h00,  1'b0};
    vt[4]  = '{8'hF0,  8'd0,   2'd2, 8'd0,  8'hFE,  1'b0};
    vt[5]  = '{8'hFF,  8'd0,   2'd2, 8'd0,  8'hFF,  1'b0};
    vt[6]  = '{8'd20,  8'd0,   2'd3, 8'd6,  8'd6,   1'b0};
    vt[7]  = '{8'hF0,  8'd0,   2'd3, 8'd6,  8'd0,   1'b0};
    vt[8]  = '{8'd3,   8'd0,   2'd3, 8'd6,  8'd3,   1'b0};
    vt[9]  = '{8'd5,   8'd0,   2'd3, 8'hFB, 8'd0,   1'b0};
    vt[10] = '{8'd100, 8'd27,  2'd1, 8'd0,  8'h7F,  1'b0};
    vt[11] = '{8'd100, 8'd28,  2'd1, 8'd0,  8'h7F,  1'b1};
    vt[12] = '{8'hC0,  8'hC0,  2'd2, 8'd0,  8'hF0,  1'b0};
    vt[13] = '{8'd40,  8'hCE,  2'd2, 8'd0,  8'hFE,  1'b0};
    vt[14] = '{8'd7,   8'hFD,  2'd2, 8'd0,  8'd4,   1'b0};
    vt[15] = '{8'hFF,  8'h80,  2'd1, 8'd0,  8'd0,   1'b1};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_ovf", {56'd0, ovf_lanes}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    n_rst = 1'b1;
    tick();
    chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
    chk("idle_overflow", {63'd0, overflow}, 64'd0);

    for (int i = 0; i < 16; i++) apply_vec(i);

    // sticky overflow: per-lane flag, clear, set-wins-over-clear
    write_row(3'd0, 64'h0000_0000_0000_000A);
    ovf_clear = 1'b1;
    tick();
    ovf_clear   = 1'b0;
    act_mode    = 2'd0;
    in_data     = rep(8'd120);
    in_valid    = 1'b1;
    frame_start = 1'b1;
    tick();
    in_valid    = 1'b0;
    frame_start = 1'b0;
    chk("ovf_lane0", {56'd0, ovf_lanes}, 64'h01);
    chk("ovf_or", {63'd0, overflow}, 64'd1);
    tick();
    chk("ovf_lane0_data", out_data, 64'h7878_7878_7878_787F);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    chk("ovf_cleared", {56'd0, ovf_lanes}, 64'd0);
    ovf_clear   = 1'b1;
    in_valid    = 1'b1;
    frame_start = 1'b1;
    tick();
    ovf_clear   = 1'b0;
    in_valid    = 1'b0;
    frame_start = 1'b0;
    chk("ovf_set_wins", {56'd0, ovf_lanes}, 64'h01);
    repeat (3) tick();

    // all rows bias 10: stream 6 beats, 1/cycle, latency 2
    for (int r = 0; r < 8; r++) write_row(3'(r), rep(8'd10));
    clr_beats();
    for (int i = 0; i < 6; i++) begin
      s_in[i]  = 8'(5 + i);
      s_exp[i] = 8'(15 + i);
    end
    s_fs[0] = 1'b1;
    run_beats(6, "stream");

    // activation mode captured with each beat
    clr_beats();
    for (int i = 0; i < 3; i++) s_in[i] = 8'hE6;
    s_fs[0] = 1'b1;
    s_mode[0] = 2'd2; s_exp[0] = 8'hFE;
    s_mode[1] = 2'd1; s_exp[1] = 8'h00;
    s_mode[2] = 2'd0; s_exp[2] = 8'hF0;
    run_beats(3, "modeflight");

    backpressure();

    // row pointer: rows hold 10*r
    for (int r = 0; r < 8; r++) write_row(3'(r), rep(8'(10 * r)));
    clr_beats();
    for (int i = 0; i < 10; i++) s_in[i] = 8'd1;
    s_fs[0] = 1'b1;
    s_exp[0] = 8'd1;  s_exp[1] = 8'd11; s_exp[2] = 8'd21; s_exp[3] = 8'd31; s_exp[4] = 8'd41;
    s_exp[5] = 8'd51; s_exp[6] = 8'd61; s_exp[7] = 8'd71; s_exp[8] = 8'd1;  s_exp[9] = 8'd11;
    run_beats(10, "rowwrap");

    s_fs[4] = 1'b1;
    s_exp[0] = 8'd1;  s_exp[1] = 8'd11; s_exp[2] = 8'd21; s_exp[3] = 8'd31; s_exp[4] = 8'd1;
    s_exp[5] = 8'd11; s_exp[6] = 8'd21; s_exp[7] = 8'd31; s_exp[8] = 8'd41; s_exp[9] = 8'd51;
    run_beats(10, "rowframe");

    clr_beats();
    for (int i = 0; i < 4; i++) s_in[i] = 8'd1;
    s_fs[0] = 1'b1; s_exp[0] = 8'd1;
    s_we[1] = 1'b1; s_wa[1] = 3'd1; s_wd[1] = 8'd99; s_exp[1] = 8'd11;
    s_fs[2] = 1'b1; s_exp[2] = 8'd1;
    s_exp[3] = 8'd100;
    run_beats(4, "rowwr");

    // reset with two beats in flight
    write_row(3'd0, rep(8'd10));
    out_ready   = 1'b0;
    in_data     = rep(8'd120);
    in_valid    = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    chk("pre_rst_ovf", {56'd0, ovf_lanes}, 64'hFF);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_data", out_data, 64'd0);
    chk("mid_rst_ovf", {56'd0, ovf_lanes}, 64'd0);
    tick();
    n_rst     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_rst_quiet%0d", i), {63'd0, out_valid}, 64'd0);
    end
    write_row(3'd0, rep(8'd3));
    write_row(3'd1, rep(8'd50));
    clr_beats();
    s_in[0] = 8'd7; s_exp[0] = 8'd10;
    s_in[1] = 8'd7; s_exp[1] = 8'd57;
    run_beats(2, "post_rst_row");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
